// File: rtl/emif_axi_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : emif_axi_mem_responder_if
//  Description : AXI4 bus bundle between the EMIF AXI shim master side and the
//                simulation memory responder. Carries the five AXI channels:
//                AW (write address), W (write data), B (write response),
//                AR (read address) and R (read data). Clock and reset are not
//                part of the bundle.
//                  master modport : drives AW/W/AR payload+valid, bready, rready
//                  slave  modport : drives awready, wready, arready, B and R
//  Revision    : 1.0  initial release
// ============================================================================
interface emif_axi_mem_responder_if #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_W_WIDTH = 7,
    parameter int ID_R_WIDTH = 7
) ();
    // write address
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [1:0]              awburst;
    logic [ID_W_WIDTH-1:0]   awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic                    awvalid;
    logic                    awready;
    // write data
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // write response
    logic [ID_W_WIDTH-1:0]   bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // read address
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [1:0]              arburst;
    logic [ID_R_WIDTH-1:0]   arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic                    arvalid;
    logic                    arready;
    // read data
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ID_R_WIDTH-1:0]   rid;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awburst, awid, awlen, awsize, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output araddr, arburst, arid, arlen, arsize, arvalid,
        input  arready,
        input  rdata, rid, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awburst, awid, awlen, awsize, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  araddr, arburst, arid, arlen, arsize, arvalid,
        output arready,
        output rdata, rid, rresp, rlast, rvalid,
        input  rready
    );
endinterface
`default_nettype wire

// File: rtl/emif_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : emif_axi_mem_responder
//  Description : AXI4 subordinate standing in for the EMIF controller in
//                simulation/bring-up builds. Backs a MEM_DEPTH x DATA_WIDTH
//                register-array memory, supports FIXED/INCR bursts of up to
//                256 full-width beats, with independent read and write
//                engines (one outstanding transaction each).
//  Ports       : axi_clk     - single rising-edge clock
//                axi_reset_n - asynchronous active-low reset
//                s_axi       - AXI4 slave modport (AW/W/B/AR/R channels)
//  Revision    : 1.0  initial release
// ============================================================================
module emif_axi_mem_responder #(
    parameter int ADDR_WIDTH = 33,
    parameter int DATA_WIDTH = 256,
    parameter int ID_W_WIDTH = 7,
    parameter int ID_R_WIDTH = 7,
    parameter int MEM_DEPTH  = 64
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    emif_axi_mem_responder_if.slave s_axi
);

    localparam int              c_nbytes      = DATA_WIDTH / 8;
    localparam int              c_ofs         = $clog2(c_nbytes);
    localparam int              c_iw          = $clog2(MEM_DEPTH);
    localparam logic [1:0]      c_burst_incr  = 2'b01;
    localparam logic [1:0]      c_resp_okay   = 2'b00;
    localparam logic [1:0]      c_resp_slverr = 2'b10;
    localparam logic [1:0]      c_resp_decerr = 2'b11;
    localparam logic [c_iw-1:0] c_idx_one     = c_iw'(1);
    localparam logic [7:0]      c_beat_one    = 8'd1;

    typedef logic [c_iw-1:0] idx_t;

    // Backing store; deliberately left out of reset.
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // ------------------------------------------------------------------
    // Address decode: beat-aligned word index, out-of-range and burst-type
    // errors. Burst-type error ranks below decode error.
    // ------------------------------------------------------------------
    idx_t       w_aw_idx, w_ar_idx;
    logic [1:0] w_aw_resp, w_ar_resp;

    assign w_aw_idx  = s_axi.awaddr[c_ofs +: c_iw];
    assign w_ar_idx  = s_axi.araddr[c_ofs +: c_iw];
    assign w_aw_resp = (|s_axi.awaddr[ADDR_WIDTH-1:c_ofs+c_iw]) ? c_resp_decerr :
                       s_axi.awburst[1]                         ? c_resp_slverr : c_resp_okay;
    assign w_ar_resp = (|s_axi.araddr[ADDR_WIDTH-1:c_ofs+c_iw]) ? c_resp_decerr :
                       s_axi.arburst[1]                         ? c_resp_slverr : c_resp_okay;

    // size is ignored (always full-width beats) and the byte offset is dropped.
    logic w_unused_ok;
    assign w_unused_ok = ^{s_axi.awsize, s_axi.arsize,
                           s_axi.awaddr[c_ofs-1:0], s_axi.araddr[c_ofs-1:0]};

    // ==================================================================
    // Write engine
    // ==================================================================
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    w_state_t              r_wstate, w_wstate_nxt;
    logic                  r_awready, r_wready, r_bvalid;
    logic [ID_W_WIDTH-1:0] r_wid, r_bid;
    logic [1:0]            r_bresp;
    logic [7:0]            r_wlen, r_wbeat;
    logic [1:0]            r_wburst;
    idx_t                  r_widx;
    logic [1:0]            r_wresp;      // error decided at address time
    logic                  r_wlast_err;  // wlast seen on the wrong beat

    logic w_aw_hs, w_w_hs, w_b_hs, w_wbeat_last, w_wlast_bad;

    assign w_aw_hs      = s_axi.awvalid && r_awready;
    assign w_w_hs       = s_axi.wvalid && r_wready;
    assign w_b_hs       = r_bvalid && s_axi.bready;
    assign w_wbeat_last = (r_wbeat == r_wlen);
    // wlast is only checked, never used to terminate the burst.
    assign w_wlast_bad  = (s_axi.wlast != w_wbeat_last);

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs)                 w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && w_wbeat_last)  w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs)                  w_wstate_nxt = W_IDLE;
            default:                              w_wstate_nxt = W_IDLE;
        endcase
    end

    // Handshake outputs are registered copies of the next state so that they
    // read 0 throughout reset and only rise on the first edge after release.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_wstate    <= W_IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= c_resp_okay;
            r_wid       <= '0;
            r_wlen      <= '0;
            r_wbeat     <= '0;
            r_wburst    <= '0;
            r_widx      <= '0;
            r_wresp     <= c_resp_okay;
            r_wlast_err <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_wid       <= s_axi.awid;
                r_wlen      <= s_axi.awlen;
                r_wburst    <= s_axi.awburst;
                r_widx      <= w_aw_idx;
                r_wresp     <= w_aw_resp;
                r_wbeat     <= '0;
                r_wlast_err <= 1'b0;
            end
            if (w_w_hs) begin
                r_wbeat <= r_wbeat + c_beat_one;
                if (r_wburst == c_burst_incr)
                    r_widx <= r_widx + c_idx_one;
                if (w_wlast_bad)
                    r_wlast_err <= 1'b1;
                if (w_wbeat_last) begin
                    r_bid   <= r_wid;
                    r_bresp <= (r_wresp != c_resp_okay)        ? r_wresp :
                               (r_wlast_err || w_wlast_bad)    ? c_resp_slverr : c_resp_okay;
                end
            end
        end
    end

    // Byte-strobed commit; suppressed for bursts rejected at address time.
    always_ff @(posedge axi_clk) begin
        if (w_w_hs && (r_wresp == c_resp_okay)) begin
            for (int b = 0; b < c_nbytes; b++) begin
                if (s_axi.wstrb[b])
                    r_mem[r_widx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bid     = r_bid;
    assign s_axi.bresp   = r_bresp;

    // ==================================================================
    // Read engine: R outputs are a register stage loaded with beat 0 on the
    // AR handshake and with the following beat on each non-final R handshake.
    // ==================================================================
    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    r_state_t              r_rstate, w_rstate_nxt;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [ID_R_WIDTH-1:0] r_rid;
    logic [1:0]            r_rresp, r_rburst;
    logic [7:0]            r_rlen, r_rbeat;
    idx_t                  r_ridx;

    logic       w_ar_hs, w_r_hs, w_ld;
    idx_t       w_ld_idx;
    logic [7:0] w_ld_beat, w_ld_len;
    logic [1:0] w_ld_resp;

    assign w_ar_hs = s_axi.arvalid && r_arready;
    assign w_r_hs  = r_rvalid && s_axi.rready;

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)            w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_hs && r_rlast)  w_rstate_nxt = R_IDLE;
            default:                         w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_ld      = 1'b0;
        w_ld_idx  = r_ridx;
        w_ld_beat = r_rbeat;
        w_ld_len  = r_rlen;
        w_ld_resp = r_rresp;
        if (w_ar_hs) begin
            w_ld      = 1'b1;
            w_ld_idx  = w_ar_idx;
            w_ld_beat = '0;
            w_ld_len  = s_axi.arlen;
            w_ld_resp = w_ar_resp;
        end else if (w_r_hs && !r_rlast) begin
            w_ld      = 1'b1;
            w_ld_idx  = (r_rburst == c_burst_incr) ? r_ridx + c_idx_one : r_ridx;
            w_ld_beat = r_rbeat + c_beat_one;
        end
    end

    // A same-edge write commit to the loaded index is not visible here, so a
    // colliding read returns the pre-write word.
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rid     <= '0;
            r_rresp   <= c_resp_okay;
            r_rburst  <= '0;
            r_rlen    <= '0;
            r_rbeat   <= '0;
            r_ridx    <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            r_rvalid  <= (w_rstate_nxt == R_DATA);
            if (w_ar_hs) begin
                r_rid    <= s_axi.arid;
                r_rburst <= s_axi.arburst;
                r_rlen   <= s_axi.arlen;
            end
            if (w_ld) begin
                r_ridx  <= w_ld_idx;
                r_rbeat <= w_ld_beat;
                r_rresp <= w_ld_resp;
                r_rlast <= (w_ld_beat == w_ld_len);
                r_rdata <= (w_ld_resp == c_resp_okay) ? r_mem[w_ld_idx] : '0;
            end
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rid     = r_rid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rlast   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_emif_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_emif_axi_mem_responder
//  Description : Scoreboard bench for emif_axi_mem_responder. Stimulus tasks
//                compute expected B/R responses from a word-array memory model
//                and queue them; a negedge monitor pops and compares on every
//                B/R handshake and checks channel stability while stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_emif_axi_mem_responder;
    localparam int AW = 33, DW = 256, IDW = 7, IDR = 7, DEPTH = 64;
    localparam int NB = DW / 8, LIMIT = 2000;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

    logic axi_clk = 1'b0;
    logic axi_reset_n = 1'b0;
    always #5 axi_clk = ~axi_clk;

    emif_axi_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                                .ID_W_WIDTH(IDW), .ID_R_WIDTH(IDR)) s_axi ();

    emif_axi_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_W_WIDTH(IDW),
                             .ID_R_WIDTH(IDR), .MEM_DEPTH(DEPTH)) dut (
        .axi_clk     (axi_clk),
        .axi_reset_n (axi_reset_n),
        .s_axi       (s_axi)
    );

    typedef struct packed { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [DW-1:0] data; logic [IDR-1:0] id; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t bq[$];
    r_exp_t rq[$];
    int n_checks = 0, n_errors = 0;
    int rready_pct = 100, bready_pct = 100;
    bit bready_block = 1'b0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] wd_buf  [256];
    logic [NB-1:0] ws_buf  [256];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Expected burst response from address range and burst type alone.
    function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr, input logic [1:0] burst);
        if (addr >= AW'(DEPTH * NB)) return 2'b11;
        if (burst >= 2'b10)          return 2'b10;
        return 2'b00;
    endfunction

    function automatic int word_of(input logic [AW-1:0] addr);
        return int'((addr / AW'(NB)) % AW'(DEPTH));
    endfunction

    // ---------------------------------------------------------------- drivers
    task automatic do_write(input logic [AW-1:0] addr, input logic [1:0] burst,
                            input logic [IDW-1:0] id, input int len, input int early_last);
        b_exp_t e;
        int idx, t;
        logic [1:0] r0;
        r0  = exp_resp(addr, burst);
        idx = word_of(addr);
        for (int i = 0; i <= len; i++) begin
            if (r0 == 2'b00)
                for (int b = 0; b < NB; b++)
                    if (ws_buf[i][b]) ref_mem[idx][b*8 +: 8] = wd_buf[i][b*8 +: 8];
            if (burst == INCR) idx = (idx + 1) % DEPTH;
        end
        e.id   = id;
        e.resp = (r0 != 2'b00) ? r0 : ((early_last >= 0) ? 2'b10 : 2'b00);
        bq.push_back(e);

        @(posedge axi_clk); #1;
        s_axi.awaddr = addr; s_axi.awburst = burst; s_axi.awid = id;
        s_axi.awlen = 8'(len); s_axi.awsize = 3'd5; s_axi.awvalid = 1'b1;
        t = 0;
        @(negedge axi_clk);
        while (!s_axi.awready && t < LIMIT) begin @(negedge axi_clk); t++; end
        if (!s_axi.awready) fail_now("aw_timeout");
        @(posedge axi_clk); #1;
        s_axi.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(3) == 0) begin s_axi.wvalid = 1'b0; @(posedge axi_clk); #1; end
            s_axi.wdata  = wd_buf[i];
            s_axi.wstrb  = ws_buf[i];
            s_axi.wlast  = (i == len) || (i == early_last);
            s_axi.wvalid = 1'b1;
            t = 0;
            @(negedge axi_clk);
            while (!s_axi.wready && t < LIMIT) begin @(negedge axi_clk); t++; end
            if (!s_axi.wready) fail_now("w_timeout");
            @(posedge axi_clk); #1;
            s_axi.wvalid = 1'b0;
            s_axi.wlast  = 1'b0;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [1:0] burst,
                           input logic [IDR-1:0] id, input int len);
        r_exp_t e;
        int idx, t;
        logic [1:0] r0;
        r0  = exp_resp(addr, burst);
        idx = word_of(addr);
        for (int i = 0; i <= len; i++) begin
            e.data = (r0 == 2'b00) ? ref_mem[idx] : '0;
            e.id   = id;
            e.resp = r0;
            e.last = (i == len);
            rq.push_back(e);
            if (burst == INCR) idx = (idx + 1) % DEPTH;
        end
        @(posedge axi_clk); #1;
        s_axi.araddr = addr; s_axi.arburst = burst; s_axi.arid = id;
        s_axi.arlen = 8'(len); s_axi.arsize = 3'd5; s_axi.arvalid = 1'b1;
        t = 0;
        @(negedge axi_clk);
        while (!s_axi.arready && t < LIMIT) begin @(negedge axi_clk); t++; end
        if (!s_axi.arready) fail_now("ar_timeout");
        @(posedge axi_clk); #1;
        s_axi.arvalid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rq.size() != 0 || bq.size() != 0) && t < 4 * LIMIT) begin @(negedge axi_clk); t++; end
        if (rq.size() != 0 || bq.size() != 0) begin
            fail_now("drain_timeout");
            rq.delete();
            bq.delete();
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(DEPTH-1) * NB + $urandom_range(NB-1));
        if ($urandom_range(7) == 0) a = a | (AW'(1) << $urandom_range(AW-1, 11));
        return a;
    endfunction

    function automatic logic [1:0] rand_burst();
        if ($urandom_range(7) == 0) return 2'($urandom_range(3, 2));
        return 2'($urandom_range(1));
    endfunction

    // ---------------------------------------------------------- ready drivers
    initial begin
        s_axi.rready = 1'b0;
        s_axi.bready = 1'b0;
        forever begin
            @(posedge axi_clk); #1;
            s_axi.rready = ($urandom_range(99) < rready_pct);
            s_axi.bready = bready_block ? 1'b0 : ($urandom_range(99) < bready_pct);
        end
    end

    // ---------------------------------------------------------------- monitor
    r_exp_t r_save;
    b_exp_t b_save;
    logic   r_stall = 1'b0, b_stall = 1'b0;

    initial begin
        forever begin
            @(negedge axi_clk);
            if (!axi_reset_n) begin
                r_stall = 1'b0;
                b_stall = 1'b0;
            end else begin
                if (r_stall) begin
                    chk("r_hold_data", s_axi.rdata, r_save.data);
                    chk("r_hold_ctl", DW'({s_axi.rvalid, s_axi.rid, s_axi.rresp, s_axi.rlast}),
                        DW'({1'b1, r_save.id, r_save.resp, r_save.last}));
                end
                if (b_stall)
                    chk("b_hold", DW'({s_axi.bvalid, s_axi.bid, s_axi.bresp}),
                        DW'({1'b1, b_save.id, b_save.resp}));
                if (s_axi.rvalid && s_axi.rready) begin
                    if (rq.size() == 0) fail_now("r_unexpected_beat");
                    else begin
                        r_exp_t e;
                        e = rq.pop_front();
                        chk("rdata", s_axi.rdata, e.data);
                        chk("r_id_resp_last", DW'({s_axi.rid, s_axi.rresp, s_axi.rlast}),
                            DW'({e.id, e.resp, e.last}));
                    end
                end
                if (s_axi.bvalid && s_axi.bready) begin
                    if (bq.size() == 0) fail_now("b_unexpected");
                    else begin
                        b_exp_t e;
                        e = bq.pop_front();
                        chk("b_id_resp", DW'({s_axi.bid, s_axi.bresp}), DW'({e.id, e.resp}));
                    end
                end
                r_stall = s_axi.rvalid && !s_axi.rready;
                r_save  = '{data: s_axi.rdata, id: s_axi.rid, resp: s_axi.rresp, last: s_axi.rlast};
                b_stall = s_axi.bvalid && !s_axi.bready;
                b_save  = '{id: s_axi.bid, resp: s_axi.bresp};
            end
        end
    end

    // ------------------------------------------------------------------ main
    initial begin
        logic [DW-1:0] nd;
        r_exp_t re;
        b_exp_t be;
        int t;

        s_axi.awaddr = '0; s_axi.awburst = '0; s_axi.awid = '0; s_axi.awlen = '0;
        s_axi.awsize = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
        s_axi.araddr = '0; s_axi.arburst = '0; s_axi.arid = '0; s_axi.arlen = '0;
        s_axi.arsize = '0; s_axi.arvalid = 1'b0;

        // Reset state
        repeat (3) @(negedge axi_clk);
        chk("reset_ctl", DW'({s_axi.awready, s_axi.arready, s_axi.wready, s_axi.bvalid, s_axi.rvalid,
                              s_axi.rlast, s_axi.bresp, s_axi.rresp, s_axi.bid, s_axi.rid}), '0);
        chk("reset_rdata", s_axi.rdata, '0);
        @(posedge axi_clk); #1 axi_reset_n = 1'b1;
        repeat (2) @(negedge axi_clk);
        chk("ready_after_reset", DW'({s_axi.awready, s_axi.arready}), DW'(2'b11));

        // Give every word a known value
        for (int i = 0; i < DEPTH; i++) begin wd_buf[i] = rand_word(); ws_buf[i] = '1; end
        do_write('0, INCR, 7'h01, DEPTH - 1, -1);
        drain();

        // INCR write/read of A0..A3 at 0x40
        for (int i = 0; i < 4; i++) begin wd_buf[i] = {32{8'(8'hA0 + i)}}; ws_buf[i] = '1; end
        do_write(33'h40, INCR, 7'h11, 3, -1);
        drain();
        do_read(33'h40, INCR, 7'h22, 3);
        drain();

        // FIXED burst with partial strobes at 0x0
        wd_buf[0] = rand_word(); ws_buf[0] = 32'h0000_000F;
        wd_buf[1] = rand_word(); ws_buf[1] = 32'hF000_0000;
        do_write(33'h0, FIXED, 7'h33, 1, -1);
        drain();
        do_read(33'h0, INCR, 7'h34, 0);
        drain();

        // Errors: decode error, WRAP read, early wlast
        wd_buf[0] = rand_word(); ws_buf[0] = '1;
        do_write(33'h1_0000_0000, INCR, 7'h40, 0, -1);
        drain();
        do_read(33'h0, INCR, 7'h41, 0);
        do_read(33'h40, WRAP, 7'h42, 3);
        drain();
        // Data equals current contents so the memory result is unaffected by
        // whether beats of this burst commit.
        for (int i = 0; i < 4; i++) begin wd_buf[i] = ref_mem[8 + i]; ws_buf[i] = '1; end
        do_write(33'h100, INCR, 7'h43, 3, 1);
        drain();

        // Back-pressure: long read with random rready, held B response
        rready_pct = 50;
        do_read(33'h0, INCR, 7'h50, 255);
        drain();
        bready_block = 1'b1;
        wd_buf[0] = rand_word(); ws_buf[0] = '1;
        do_write(AW'(20 * NB), INCR, 7'h5A, 0, -1);
        t = 0;
        while (!s_axi.bvalid && t < LIMIT) begin @(negedge axi_clk); t++; end
        if (!s_axi.bvalid) fail_now("bvalid_timeout");
        repeat (10) begin
            @(negedge axi_clk);
            chk("bvalid_held", DW'({s_axi.bvalid, s_axi.bid}), DW'({1'b1, 7'h5A}));
        end
        bready_block = 1'b0;
        drain();

        // Index wrap 63 -> 0
        for (int i = 0; i < 2; i++) begin wd_buf[i] = rand_word(); ws_buf[i] = '1; end
        do_write(AW'(63 * NB), INCR, 7'h60, 1, -1);
        drain();
        do_read(AW'(63 * NB), INCR, 7'h61, 1);
        drain();

        // Write commit and read load on the same index in the same cycle
        nd = rand_word();
        re = '{data: ref_mem[9], id: 7'h71, resp: 2'b00, last: 1'b1};
        rq.push_back(re);
        be = '{id: 7'h70, resp: 2'b00};
        bq.push_back(be);
        ref_mem[9] = nd;
        @(posedge axi_clk); #1;
        s_axi.awaddr = AW'(9 * NB); s_axi.awburst = INCR; s_axi.awid = 7'h70;
        s_axi.awlen = 8'd0; s_axi.awvalid = 1'b1;
        t = 0;
        @(negedge axi_clk);
        while (!s_axi.awready && t < LIMIT) begin @(negedge axi_clk); t++; end
        if (!s_axi.awready) fail_now("aw_timeout_conc");
        @(posedge axi_clk); #1;
        s_axi.awvalid = 1'b0;
        s_axi.wdata = nd; s_axi.wstrb = '1; s_axi.wlast = 1'b1; s_axi.wvalid = 1'b1;
        s_axi.araddr = AW'(9 * NB); s_axi.arburst = INCR; s_axi.arid = 7'h71;
        s_axi.arlen = 8'd0; s_axi.arvalid = 1'b1;
        @(negedge axi_clk);
        chk("conc_ready", DW'({s_axi.wready, s_axi.arready}), DW'(2'b11));
        @(posedge axi_clk); #1;
        s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0; s_axi.arvalid = 1'b0;
        drain();
        do_read(AW'(9 * NB), FIXED, 7'h72, 0);
        drain();

        // Randomised traffic
        for (int it = 0; it < 24; it++) begin
            int len;
            rready_pct = $urandom_range(100, 30);
            bready_pct = $urandom_range(100, 30);
            len = (it % 6 == 0) ? $urandom_range(63, 16) : $urandom_range(15);
            for (int i = 0; i <= len; i++) begin wd_buf[i] = rand_word(); ws_buf[i] = NB'($urandom); end
            do_write(rand_addr(), rand_burst(), IDW'($urandom), len, -1);
            drain();
            do_read(rand_addr(), rand_burst(), IDR'($urandom), $urandom_range(20));
            drain();
        end

        // Reset in the middle of a read burst; memory must survive
        rready_pct = 100;
        bready_pct = 100;
        do_read(33'h0, INCR, 7'h7E, 255);
        repeat (5) @(posedge axi_clk);
        #2 axi_reset_n = 1'b0;
        #1;
        chk("async_reset_ctl", DW'({s_axi.rvalid, s_axi.arready, s_axi.awready, s_axi.wready, s_axi.bvalid}), '0);
        rq.delete();
        bq.delete();
        repeat (3) @(posedge axi_clk);
        #1 axi_reset_n = 1'b1;
        repeat (2) @(negedge axi_clk);
        chk("ready_after_midreset", DW'({s_axi.awready, s_axi.arready, s_axi.rvalid}), DW'(3'b110));
        do_read(33'h40, INCR, 7'h7F, 3);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
